// File: rtl/sm3_pkg.sv
// Shared definitions for the SM3 message padder: block geometry, pad marker
// word, bit-length width and the padder state encoding.
package sm3_pkg;

    localparam int unsigned Sm3BlkWords = 16;
    localparam logic [31:0] Sm3PadWord  = 32'h8000_0000;
    localparam int unsigned LenW        = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        PAD80 = 3'd2,
        ZERO  = 3'd3,
        LENHI = 3'd4,
        LENLO = 3'd5
    } sm3_pad_state_e;

    function automatic logic [2:0] mask_bytes(input logic [3:0] mask);
        return 3'(mask[0]) + 3'(mask[1]) + 3'(mask[2]) + 3'(mask[3]);
    endfunction

endpackage

// File: rtl/sm3_msg_pad_if.sv
// Message-in / padded-block-out stream bundle around sm3_msg_pad.
interface sm3_msg_pad_if;

    logic [31:0] msg_d;
    logic [3:0]  msg_vld_byte;
    logic        msg_vld;
    logic        msg_lst;
    logic        msg_rdy;
    logic [31:0] blk_d;
    logic        blk_vld;
    logic        blk_rdy;
    logic        blk_eob;
    logic        blk_lst;
    logic        err;

    modport master (
        output msg_d, msg_vld_byte, msg_vld, msg_lst, blk_rdy,
        input  msg_rdy, blk_d, blk_vld, blk_eob, blk_lst, err
    );

    modport slave (
        input  msg_d, msg_vld_byte, msg_vld, msg_lst, blk_rdy,
        output msg_rdy, blk_d, blk_vld, blk_eob, blk_lst, err
    );

endinterface

// File: rtl/sm3_msg_pad.sv
// SM3 message padder: forwards message words, then appends the 0x80 marker,
// zero fill and the 64-bit message bit length to complete 512-bit blocks.
//
// state | meaning
// IDLE  | waiting for the first word of a message (LENLO word may still be draining)
// DATA  | mid-message, accepting full words
// PAD80 | last word was full; next emitted word is the 0x80000000 marker
// ZERO  | emitting zero fill until the word index reaches 14
// LENHI | next emitted word is the upper 32 bits of the bit length
// LENLO | next emitted word is the lower 32 bits of the bit length (last of message)
module sm3_msg_pad
    import sm3_pkg::*;
#(
    parameter int unsigned LenW = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic [31:0] msg_d_i,
    input  logic [3:0]  msg_vld_byte_i,
    input  logic        msg_vld_i,
    input  logic        msg_lst_i,
    output logic        msg_rdy_o,
    output logic [31:0] blk_d_o,
    output logic        blk_vld_o,
    input  logic        blk_rdy_i,
    output logic        blk_eob_o,
    output logic        blk_lst_o,
    output logic        err_o
);

    localparam logic [3:0] IdxLast = 4'(Sm3BlkWords - 1);
    localparam logic [3:0] IdxLenHi = 4'(Sm3BlkWords - 2);

    sm3_pad_state_e    state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [LenW-1:0]   bitcnt_q, bitcnt_d;
    logic [31:0]       blk_d_q, blk_d_d;
    logic              blk_vld_q, blk_vld_d;
    logic              blk_eob_q, blk_eob_d;
    logic              blk_lst_q, blk_lst_d;
    logic              err_q, err_d;

    logic              out_free;
    logic              accept;
    logic              mask_legal;
    logic [3:0]        eff_mask;
    logic [31:0]       pad_word;
    logic [3:0]        idx_inc;
    logic              load;
    logic [63:0]       len_w;
    sm3_pad_state_e    after_fill;

    assign out_free  = !blk_vld_q || blk_rdy_i;
    assign msg_rdy_o = ((state_q == IDLE) || (state_q == DATA)) && out_free;
    assign accept    = msg_vld_i && msg_rdy_o && !clr_i;
    assign len_w     = 64'(bitcnt_q);
    assign idx_inc   = idx_q + 4'd1;
    // Zero fill is skipped entirely when the word just loaded leaves the index at 14.
    assign after_fill = (idx_inc == IdxLenHi) ? LENHI : ZERO;

    always_comb begin
        if (msg_lst_i) begin
            mask_legal = msg_vld_byte_i inside {4'h0, 4'h8, 4'hC, 4'hE, 4'hF};
        end else begin
            mask_legal = (msg_vld_byte_i == 4'hF);
        end
        eff_mask = mask_legal ? msg_vld_byte_i : 4'hF;

        case (eff_mask)
            4'h0:    pad_word = Sm3PadWord;
            4'h8:    pad_word = {msg_d_i[31:24], 8'h80, 16'h0000};
            4'hC:    pad_word = {msg_d_i[31:16], 8'h80, 8'h00};
            4'hE:    pad_word = {msg_d_i[31:8], 8'h80};
            default: pad_word = msg_d_i;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        bitcnt_d  = bitcnt_q;
        blk_d_d   = blk_d_q;
        blk_vld_d = blk_vld_q && !blk_rdy_i;
        blk_eob_d = blk_eob_q;
        blk_lst_d = blk_lst_q;
        err_d     = 1'b0;
        load      = 1'b0;

        if (clr_i) begin
            state_d   = IDLE;
            idx_d     = 4'd0;
            bitcnt_d  = '0;
            blk_vld_d = 1'b0;
            blk_eob_d = 1'b0;
            blk_lst_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, DATA: begin
                    if (accept) begin
                        load     = 1'b1;
                        blk_d_d  = pad_word;
                        err_d    = !mask_legal;
                        bitcnt_d = bitcnt_q + LenW'({mask_bytes(eff_mask), 3'b000});
                        if (!msg_lst_i) begin
                            state_d = DATA;
                        end else if (eff_mask == 4'hF) begin
                            state_d = PAD80;
                        end else begin
                            state_d = after_fill;
                        end
                    end
                end
                PAD80: begin
                    if (out_free) begin
                        load    = 1'b1;
                        blk_d_d = Sm3PadWord;
                        state_d = after_fill;
                    end
                end
                ZERO: begin
                    if (out_free) begin
                        load    = 1'b1;
                        blk_d_d = 32'h0000_0000;
                        state_d = after_fill;
                    end
                end
                LENHI: begin
                    if (out_free) begin
                        load    = 1'b1;
                        blk_d_d = len_w[63:32];
                        state_d = LENLO;
                    end
                end
                LENLO: begin
                    if (out_free) begin
                        load     = 1'b1;
                        blk_d_d  = len_w[31:0];
                        bitcnt_d = '0;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (load) begin
                blk_vld_d = 1'b1;
                blk_eob_d = (idx_q == IdxLast);
                blk_lst_d = (state_q == LENLO);
                idx_d     = idx_inc;
            end else if (blk_rdy_i) begin
                blk_eob_d = 1'b0;
                blk_lst_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            bitcnt_q  <= '0;
            blk_d_q   <= 32'h0000_0000;
            blk_vld_q <= 1'b0;
            blk_eob_q <= 1'b0;
            blk_lst_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            bitcnt_q  <= bitcnt_d;
            blk_d_q   <= blk_d_d;
            blk_vld_q <= blk_vld_d;
            blk_eob_q <= blk_eob_d;
            blk_lst_q <= blk_lst_d;
            err_q     <= err_d;
        end
    end

    assign blk_d_o   = blk_d_q;
    assign blk_vld_o = blk_vld_q;
    assign blk_eob_o = blk_eob_q;
    assign blk_lst_o = blk_lst_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_sm3_msg_pad.sv
// Directed bench for sm3_msg_pad: known SM3 padding vectors, stalls, abort,
// reset mid-message and illegal byte masks.
module tb_sm3_msg_pad;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    sm3_msg_pad_if bus ();

    sm3_msg_pad #(.LenW(64)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clr_i          (clr),
        .msg_d_i        (bus.msg_d),
        .msg_vld_byte_i (bus.msg_vld_byte),
        .msg_vld_i      (bus.msg_vld),
        .msg_lst_i      (bus.msg_lst),
        .msg_rdy_o      (bus.msg_rdy),
        .blk_d_o        (bus.blk_d),
        .blk_vld_o      (bus.blk_vld),
        .blk_rdy_i      (bus.blk_rdy),
        .blk_eob_o      (bus.blk_eob),
        .blk_lst_o      (bus.blk_lst),
        .err_o          (bus.err)
    );

    typedef struct {
        logic [31:0] d;
        logic        eob;
        logic        lst;
    } cap_t;

    cap_t cap_q [$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   err_cnt = 0;
    int   stall_seen = 0;
    int   stall_viol = 0;
    logic stall_en = 1'b0;

    logic        prev_stall = 1'b0;
    logic [31:0] prev_d = '0;
    logic        prev_eob = 1'b0;
    logic        prev_lst = 1'b0;

    // Output observer: a word counts as transferred when vld and rdy are both high mid-cycle.
    always @(negedge clk) begin
        if (bus.blk_vld === 1'b1 && bus.blk_rdy === 1'b1)
            cap_q.push_back('{bus.blk_d, bus.blk_eob, bus.blk_lst});
        if (bus.err === 1'b1) err_cnt++;
        if (prev_stall && rst_n && !clr) begin
            stall_seen++;
            if (bus.blk_vld !== 1'b1 || bus.blk_d !== prev_d ||
                bus.blk_eob !== prev_eob || bus.blk_lst !== prev_lst)
                stall_viol++;
        end
        prev_stall = (bus.blk_vld === 1'b1) && (bus.blk_rdy === 1'b0);
        prev_d     = bus.blk_d;
        prev_eob   = bus.blk_eob;
        prev_lst   = bus.blk_lst;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic send_word(input logic [31:0] d, input logic [3:0] m, input logic l);
        int   n;
        logic taken;
        n = 0;
        taken = 1'b0;
        bus.msg_d = d;
        bus.msg_vld_byte = m;
        bus.msg_lst = l;
        bus.msg_vld = 1'b1;
        while (!taken && n < 500) begin
            @(negedge clk);
            taken = bus.msg_rdy;
            @(posedge clk);
            #1;
            n++;
        end
        bus.msg_vld = 1'b0;
        bus.msg_lst = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int cyc;
        cyc = 0;
        while (cap_q.size() < n && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.msg_d = '0;
        bus.msg_vld_byte = 4'h0;
        bus.msg_vld = 1'b0;
        bus.msg_lst = 1'b0;
        bus.blk_rdy = 1'b1;
        rst_n = 1'b0;
        #23;
        n_cmp++;
        if ({bus.blk_vld, bus.blk_eob, bus.blk_lst, bus.err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got vld/eob/lst/err %b, want 0000",
                     {bus.blk_vld, bus.blk_eob, bus.blk_lst, bus.err});
        end
        n_cmp++;
        if (bus.blk_d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, want 00000000", bus.blk_d);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.msg_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rdy: got %b, want 1", bus.msg_rdy);
        end
    endtask

    task automatic test_abc(input string tag);
        logic [31:0] exp_d [16];
        for (int i = 0; i < 16; i++) exp_d[i] = 32'h0;
        exp_d[0] = 32'h6162_6380;
        exp_d[15] = 32'h0000_0018;
        cap_q.delete();
        send_word(32'h6162_6300, 4'hE, 1'b1);
        wait_words(16);
        n_cmp++;
        if (cap_q.size() != 16) begin
            n_fail++;
            $display("FAIL %s_count: got %0d words, want 16", tag, cap_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_cmp++;
                if (cap_q[i].d !== exp_d[i] || cap_q[i].eob !== (i == 15) || cap_q[i].lst !== (i == 15)) begin
                    n_fail++;
                    $display("FAIL %s_w%0d: got %h eob%b lst%b, want %h eob%b lst%b", tag, i,
                             cap_q[i].d, cap_q[i].eob, cap_q[i].lst, exp_d[i], i == 15, i == 15);
                end
            end
        end
        cap_q.delete();
    endtask

    task automatic test_empty();
        logic [31:0] exp_d [16];
        for (int i = 0; i < 16; i++) exp_d[i] = 32'h0;
        exp_d[0] = 32'h8000_0000;
        cap_q.delete();
        send_word(32'hDEAD_BEEF, 4'h0, 1'b1);
        wait_words(16);
        n_cmp++;
        if (cap_q.size() != 16) begin
            n_fail++;
            $display("FAIL empty_count: got %0d words, want 16", cap_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_cmp++;
                if (cap_q[i].d !== exp_d[i] || cap_q[i].eob !== (i == 15) || cap_q[i].lst !== (i == 15)) begin
                    n_fail++;
                    $display("FAIL empty_w%0d: got %h eob%b lst%b, want %h eob%b lst%b", i,
                             cap_q[i].d, cap_q[i].eob, cap_q[i].lst, exp_d[i], i == 15, i == 15);
                end
            end
        end
        cap_q.delete();
    endtask

    task automatic test_two_blocks();
        logic [31:0] exp_d [32];
        for (int i = 0; i < 32; i++) exp_d[i] = 32'h0;
        for (int i = 0; i < 14; i++) exp_d[i] = 32'h1000_0000 + 32'(i);
        exp_d[14] = 32'h8000_0000;
        exp_d[31] = 32'h0000_01C0;
        cap_q.delete();
        for (int i = 0; i < 14; i++) send_word(32'h1000_0000 + 32'(i), 4'hF, i == 13);
        wait_words(32);
        n_cmp++;
        if (cap_q.size() != 32) begin
            n_fail++;
            $display("FAIL two_blk_count: got %0d words, want 32", cap_q.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                n_cmp++;
                if (cap_q[i].d !== exp_d[i] || cap_q[i].eob !== (i == 15 || i == 31) || cap_q[i].lst !== (i == 31)) begin
                    n_fail++;
                    $display("FAIL two_blk_w%0d: got %h eob%b lst%b, want %h eob%b lst%b", i,
                             cap_q[i].d, cap_q[i].eob, cap_q[i].lst, exp_d[i], i == 15 || i == 31, i == 31);
                end
            end
        end
        cap_q.delete();
    endtask

    task automatic test_stall();
        logic [31:0] exp_d [32];
        for (int i = 0; i < 32; i++) exp_d[i] = 32'h0;
        for (int i = 0; i < 16; i++) exp_d[i] = 32'h6162_6364;
        exp_d[16] = 32'h8000_0000;
        exp_d[31] = 32'h0000_0200;
        cap_q.delete();
        stall_seen = 0;
        stall_viol = 0;
        stall_en = 1'b1;
        fork
            begin
                while (stall_en) begin
                    @(posedge clk);
                    #1;
                    if (stall_en) bus.blk_rdy = ($urandom_range(0, 2) != 0);
                end
            end
        join_none
        for (int i = 0; i < 16; i++) send_word(32'h6162_6364, 4'hF, i == 15);
        wait_words(32);
        stall_en = 1'b0;
        bus.blk_rdy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (cap_q.size() != 32) begin
            n_fail++;
            $display("FAIL stall_count: got %0d words, want 32", cap_q.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                n_cmp++;
                if (cap_q[i].d !== exp_d[i] || cap_q[i].eob !== (i == 15 || i == 31) || cap_q[i].lst !== (i == 31)) begin
                    n_fail++;
                    $display("FAIL stall_w%0d: got %h eob%b lst%b, want %h eob%b lst%b", i,
                             cap_q[i].d, cap_q[i].eob, cap_q[i].lst, exp_d[i], i == 15 || i == 31, i == 31);
                end
            end
        end
        n_cmp++;
        if (stall_viol != 0) begin
            n_fail++;
            $display("FAIL stall_hold: got %0d unstable stalled cycles, want 0", stall_viol);
        end
        n_cmp++;
        if (stall_seen == 0) begin
            n_fail++;
            $display("FAIL stall_seen: got %0d stalled cycles, want >0", stall_seen);
        end
        cap_q.delete();
    endtask

    task automatic test_clr();
        for (int i = 0; i < 5; i++) send_word(32'hA5A5_0000 + 32'(i), 4'hF, 1'b0);
        // Abort while a last word is offered in the same cycle; it must be dropped.
        bus.msg_d = 32'h1234_5600;
        bus.msg_vld_byte = 4'hE;
        bus.msg_lst = 1'b1;
        bus.msg_vld = 1'b1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        bus.msg_vld = 1'b0;
        bus.msg_lst = 1'b0;
        n_cmp++;
        if (bus.blk_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_vld: got %b, want 0", bus.blk_vld);
        end
        cap_q.delete();
        repeat (20) @(posedge clk);
        #1;
        n_cmp++;
        if (cap_q.size() != 0) begin
            n_fail++;
            $display("FAIL clr_drop: got %0d words after abort, want 0", cap_q.size());
        end
        test_abc("clr_abc");
    endtask

    task automatic test_reset_mid();
        cap_q.delete();
        for (int i = 0; i < 3; i++) send_word(32'hCAFE_0000 + 32'(i), 4'hF, 1'b0);
        rst_n = 1'b0;
        #2;
        cap_q.delete();
        n_cmp++;
        if (bus.blk_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_vld: got %b, want 0", bus.blk_vld);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        n_cmp++;
        if (cap_q.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_drop: got %0d words after reset, want 0", cap_q.size());
        end
        n_cmp++;
        if (bus.msg_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_rdy: got %b, want 1", bus.msg_rdy);
        end
        cap_q.delete();
    endtask

    task automatic test_bad_mask();
        int err0;
        err0 = err_cnt;
        cap_q.delete();
        send_word(32'h1122_3344, 4'hA, 1'b0);
        send_word(32'h5566_7788, 4'h0, 1'b1);
        wait_words(16);
        n_cmp++;
        if (err_cnt - err0 != 1) begin
            n_fail++;
            $display("FAIL err_pulse: got %0d err cycles, want 1", err_cnt - err0);
        end
        n_cmp++;
        if (cap_q.size() != 16) begin
            n_fail++;
            $display("FAIL err_count: got %0d words, want 16", cap_q.size());
        end else begin
            n_cmp++;
            if (cap_q[0].d !== 32'h1122_3344) begin
                n_fail++;
                $display("FAIL err_w0: got %h, want 11223344", cap_q[0].d);
            end
            n_cmp++;
            if (cap_q[1].d !== 32'h8000_0000) begin
                n_fail++;
                $display("FAIL err_w1: got %h, want 80000000", cap_q[1].d);
            end
            n_cmp++;
            if (cap_q[14].d !== 32'h0 || cap_q[15].d !== 32'h0000_0020 || cap_q[15].lst !== 1'b1) begin
                n_fail++;
                $display("FAIL err_len: got %h %h lst%b, want 00000000 00000020 lst1",
                         cap_q[14].d, cap_q[15].d, cap_q[15].lst);
            end
        end
        cap_q.delete();
    endtask

    initial begin
        test_reset();
        test_abc("abc");
        test_empty();
        test_two_blocks();
        test_stall();
        test_clr();
        test_reset_mid();
        test_bad_mask();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sm3_msg_pad.md
SM3_MSG_PAD -- requirements
Module: sm3_msg_pad

Interface
REQ-001 SHALL have parameter: LenW, 64, width of the message bit-length counter (fixed at 64 for SM3).
REQ-002 SHALL have port: clk_i  input  1  single clock; all logic on the rising edge.
REQ-003 SHALL have port: rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: clr_i  input  1  synchronous abort; discards the message in progress.
REQ-005 SHALL have port: msg_d_i  input  32  message word, big-endian (byte 3 = [31:24] is first).
REQ-006 SHALL have port: msg_vld_byte_i  input  4  valid-byte mask, MSB-first.
REQ-007 SHALL have port: msg_vld_i  input  1  message word valid.
REQ-008 SHALL have port: msg_lst_i  input  1  current word is the final message word.
REQ-009 SHALL have port: msg_rdy_o  output  1  word accepted when msg_vld_i && msg_rdy_o.
REQ-010 SHALL have port: blk_d_o  output  32  padded block word to the compressor.
REQ-011 SHALL have port: blk_vld_o  output  1  blk_d_o valid.
REQ-012 SHALL have port: blk_rdy_i  input  1  compressor accepts a word when blk_vld_o && blk_rdy_i.
REQ-013 SHALL have port: blk_eob_o  output  1  word 15 of a 512-bit block.
REQ-014 SHALL have port: blk_lst_o  output  1  word 15 of the final block of the message.
REQ-015 SHALL have port: err_o  output  1  one-cycle pulse on an illegal byte mask.

Function
REQ-016 SHALL use states IDLE, DATA, PAD80, ZERO, LENHI, LENLO.
REQ-017 SHALL leave IDLE for DATA on the first accepted word.
REQ-018 SHALL accept non-last words only with mask 4'hF.
REQ-019 SHALL accept last words with masks 4'h0, 4'h8, 4'hC, 4'hE or 4'hF.
REQ-020 SHALL, for any other mask, pulse err_o in the acceptance cycle and treat the mask as 4'hF.
REQ-021 SHALL register outputs: an accepted word appears on blk_d_o one cycle later; throughput is one word per cycle.
REQ-022 SHALL assert msg_rdy_o only in IDLE/DATA, and only when the output register is empty or blk_rdy_i=1.
REQ-023 SHALL hold blk_d_o, blk_vld_o, blk_eob_o and blk_lst_o stable while blk_vld_o=1 and blk_rdy_i=0.
REQ-024 SHALL keep a 4-bit word index that advances per output handshake and wraps 15->0; blk_eob_o=1 when the index is 15.
REQ-025 SHALL keep a LenW-bit bit counter, adding 8 × (popcount of the accepted mask) and wrapping modulo 2^64.
REQ-026 SHALL emit a partial last word (mask below 4'hF) with invalid bytes zeroed and 0x80 in the first invalid byte, then go to ZERO.
REQ-027 SHALL emit a last word with mask 4'hF unchanged, then go to PAD80; PAD80 emits 0x80000000.
REQ-028 SHALL, in ZERO, emit 0x00000000 until the index reaches 14, wrapping through 15 into a new block when needed.
REQ-029 SHALL emit the length high word in LENHI at index 14, then the low word in LENLO at index 15.
REQ-030 SHALL assert blk_lst_o with the LENLO word and return to IDLE on its handshake.
REQ-031 SHALL, when clr_i=1, return to IDLE next cycle, zero the counters, drop blk_vld_o and ignore input that cycle.
REQ-032 SHALL give clr_i priority over a simultaneous handshake.

Reset
REQ-033 SHALL, while rst_ni=0, asynchronously set state=IDLE, index=0, bit counter=0, blk_d_o=0, blk_vld_o=0, blk_eob_o=0, blk_lst_o=0, err_o=0.
REQ-034 SHALL drive msg_rdy_o=1 after reset release, since it is derived from IDLE with an empty output register.
REQ-035 SHALL discard an in-flight message on reset mid-operation, with no partial block emitted afterwards.

Structure
REQ-036 SHALL place the state enum, Sm3BlkWords=16, Sm3PadWord=32'h80000000 and LenW in shared package sm3_pkg.
REQ-037 SHALL be a single module with no sub-module; the mask-to-pad mux is inline combinational logic.

Verification
REQ-038 SHALL cover: "abc" = 0x61626300, mask 4'hE, lst -> 0x61626380, 14×0, 0x00000018; blk_lst_o on word 15.
REQ-039 SHALL cover: empty message, mask 4'h0, lst -> 0x80000000, 14×0, 0x00000000; single block.
REQ-040 SHALL cover: 14 full words, last mask 4'hF -> words 0-13 data, word 14 0x80000000, word 15 0, second block 14×0, 0x00000000, 0x000001C0.
REQ-041 SHALL cover: random blk_rdy_i stalls during the 64-byte message (16 × 0x61626364) -> outputs stable under stall; 32 words total; final word 0x00000200.
REQ-042 SHALL cover: clr_i asserted after word 5 of a message, then "abc" sent -> output identical to REQ-038.
REQ-043 SHALL cover: non-last word with mask 4'hA -> err_o pulses once and the bit count includes 32 bits for that word.
